// File: rtl/rx_cmd_sequencer.sv
// Command-frame controller behind the debug UART receiver: assembles opcode(+payload)
// frames from received bytes and issues them to the debug FSM over valid/ready.
module rx_cmd_sequencer #(
    parameter int          PAYLOAD_BYTES = 4,
    parameter int          TIMEOUT_TICKS = 320,
    parameter logic [7:0]  CMD_STEP      = 8'h01,
    parameter logic [7:0]  CMD_RUN       = 8'h02,
    parameter logic [7:0]  CMD_RESET     = 8'h03,
    parameter logic [7:0]  CMD_LOAD      = 8'h04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tick,
    input  logic        rx_done,
    input  logic [7:0]  dout,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_data,
    output logic        busy,
    output logic        err_unknown,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [1:0]  dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_code/cmd_data are held stable from cmd_valid rising until that transfer.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_ISSUE   = 2'd2
    } state_t;

    localparam logic [1:0]  LAST_N   = 2'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_TICKS - 1);

    state_t      r_state;
    logic [1:0]  r_n;
    logic [15:0] r_tcnt;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_code;
    logic [31:0] r_cmd_data;
    logic        r_busy;
    logic        r_err_unknown;
    logic        r_err_timeout;
    logic        r_err_overrun;

    logic        w_no_payload_op;

    assign w_no_payload_op = (dout == CMD_STEP) || (dout == CMD_RUN) || (dout == CMD_RESET);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_n           <= 2'd0;
            r_tcnt        <= 16'd0;
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= 8'd0;
            r_cmd_data    <= 32'd0;
            r_busy        <= 1'b0;
            r_err_unknown <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_unknown <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_done) begin
                        if (w_no_payload_op) begin
                            r_cmd_code  <= dout;
                            r_cmd_data  <= 32'd0;
                            r_cmd_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else if (dout == CMD_LOAD) begin
                            r_cmd_code <= dout;
                            r_cmd_data <= 32'd0;
                            r_n        <= 2'd0;
                            r_tcnt     <= 16'd0;
                            r_busy     <= 1'b1;
                            r_state    <= S_PAYLOAD;
                        end else begin
                            r_err_unknown <= 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    // A byte in the same cycle as a tick takes priority and restarts the timeout.
                    if (rx_done) begin
                        r_cmd_data[{r_n, 3'b000} +: 8] <= dout;
                        r_tcnt <= 16'd0;
                        if (r_n == LAST_N) begin
                            r_cmd_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_n <= r_n + 2'd1;
                        end
                    end else if (s_tick) begin
                        if (r_tcnt == TMO_LAST) begin
                            r_err_timeout <= 1'b1;
                            r_cmd_data    <= 32'd0;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_tcnt <= r_tcnt + 16'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (rx_done) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (r_cmd_valid && cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign cmd_data    = r_cmd_data;
    assign busy        = r_busy;
    assign err_unknown = r_err_unknown;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Directed and randomized checks of rx_cmd_sequencer against a frame-level reference model.
module tb_rx_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        s_tick;
    logic        rx_done;
    logic [7:0]  dout;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        busy;
    logic        err_unknown;
    logic        err_timeout;
    logic        err_overrun;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];

    rx_cmd_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .s_tick      (s_tick),
        .rx_done     (rx_done),
        .dout        (dout),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_data    (cmd_data),
        .busy        (busy),
        .err_unknown (err_unknown),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drivers: inputs change on negedge; outputs are sampled on the following negedge.
    task automatic send_byte(input logic [7:0] b, input logic tk);
        @(negedge clk);
        rx_done = 1'b1;
        dout    = b;
        s_tick  = tk;
        @(negedge clk);
        rx_done = 1'b0;
        s_tick  = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    endtask

    task automatic handshake(input string tag);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, "_valid_drop"}, 40'(cmd_valid), 40'd0);
        chk({tag, "_busy_drop"}, 40'(busy), 40'd0);
    endtask

    task automatic send_load(input logic [31:0] data);
        send_byte(8'h04, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(data[8*i +: 8], 1'b0);
        end
    endtask

    initial begin
        logic [39:0] got;
        logic [39:0] want;
        logic [7:0]  b;
        logic [7:0]  code;
        logic [31:0] data;
        int          kind;

        rst = 1'b0; s_tick = 1'b0; rx_done = 1'b0; dout = 8'h00; cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 40'(cmd_valid), 40'd0);
        chk("rst_code_data", {cmd_code, cmd_data}, 40'd0);
        chk("rst_flags", 40'({busy, err_unknown, err_timeout, err_overrun}), 40'd0);
        chk("rst_state", 40'(dbg_state), 40'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: single no-payload command
        send_byte(8'h01, 1'b0);
        chk("t1_valid", 40'(cmd_valid), 40'd1);
        chk("t1_cmd", {cmd_code, cmd_data}, {8'h01, 32'h0});
        chk("t1_busy", 40'(busy), 40'd1);
        handshake("t1");

        // 2: load frame with stalled ready
        send_load(32'hDEADBEEF);
        chk("t2_valid", 40'(cmd_valid), 40'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_stall_cmd", {cmd_code, cmd_data}, {8'h04, 32'hDEADBEEF});
            chk("t2_stall_valid", 40'(cmd_valid), 40'd1);
        end
        handshake("t2");

        // 3: unknown opcode
        send_byte(8'h7F, 1'b0);
        chk("t3_unknown", 40'(err_unknown), 40'd1);
        chk("t3_busy_valid", 40'({busy, cmd_valid}), 40'd0);
        @(negedge clk);
        chk("t3_unknown_pulse", 40'(err_unknown), 40'd0);
        send_byte(8'h02, 1'b0);
        chk("t3_cmd", {7'd0, cmd_valid, cmd_code}, {7'd0, 1'b1, 8'h02});
        handshake("t3");

        // 4: inter-byte timeout
        send_byte(8'h04, 1'b0);
        send_byte(8'h11, 1'b0);
        tick(319);
        chk("t4_before_tmo", 40'({busy, err_timeout}), 40'b10);
        tick(1);
        chk("t4_tmo", 40'({busy, err_timeout}), 40'b01);
        chk("t4_data_clr", 40'(cmd_data), 40'd0);
        @(negedge clk);
        chk("t4_tmo_pulse", 40'(err_timeout), 40'd0);
        send_byte(8'h01, 1'b0);
        chk("t4_cmd", {7'd0, cmd_valid, cmd_code}, {7'd0, 1'b1, 8'h01});
        handshake("t4");

        // 5: overrun while holding a command
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        chk("t5_overrun", 40'(err_overrun), 40'd1);
        chk("t5_cmd_kept", {7'd0, cmd_valid, cmd_code}, {7'd0, 1'b1, 8'h01});
        @(negedge clk);
        chk("t5_overrun_pulse", 40'(err_overrun), 40'd0);
        handshake("t5");
        send_byte(8'h02, 1'b0);
        chk("t5_cmd2", {7'd0, cmd_valid, cmd_code}, {7'd0, 1'b1, 8'h02});
        handshake("t5b");

        // 6: async reset mid-payload
        send_byte(8'h04, 1'b0);
        send_byte(8'hAA, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_rst_outs", {cmd_code, cmd_data}, 40'd0);
        chk("t6_rst_flags", 40'({cmd_valid, busy, err_unknown, err_timeout, err_overrun}), 40'd0);
        @(negedge clk);
        rst = 1'b1;
        send_load(32'h04030201);
        chk("t6_cmd", {cmd_code, cmd_data}, {8'h04, 32'h04030201});
        handshake("t6");

        // Randomized frames: the model only knows which opcodes are legal and
        // that payload bytes pack little-endian into the command word.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                do b = 8'($urandom_range(0, 255)); while (b >= 8'h01 && b <= 8'h04);
                send_byte(b, 1'($urandom_range(0, 1)));
                chk("rnd_unknown", 40'({err_unknown, busy, cmd_valid}), 40'b100);
                continue;
            end
            if (kind < 6) begin
                code = 8'($urandom_range(1, 3));
                exp_q.push_back({code, 32'h0});
                send_byte(code, 1'b0);
            end else begin
                data = $urandom;
                exp_q.push_back({8'h04, data});
                send_byte(8'h04, 1'b0);
                for (int i = 0; i < 4; i++) begin
                    tick($urandom_range(0, 30));
                    send_byte(data[8*i +: 8], 1'($urandom_range(0, 1)));
                end
            end
            got  = {cmd_code, cmd_data};
            want = exp_q.pop_front();
            chk("rnd_valid_busy", 40'({cmd_valid, busy}), 40'b11);
            chk("rnd_cmd", got, want);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                send_byte(8'($urandom_range(0, 255)), 1'b0);
                chk("rnd_overrun", 40'(err_overrun), 40'd1);
                chk("rnd_cmd_hold", {cmd_code, cmd_data}, want);
            end
            handshake("rnd");
            if ($urandom_range(0, 3) == 0) begin
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                chk("rnd_idle_ready", 40'({cmd_valid, busy}), 40'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
